conv_calc_seq: RTL and testbench



---
 rtl/conv_pkg.sv | 59 +++++
 rtl/conv_dot.sv | 35 +++
 rtl/mul_24x24.sv | 14 +
 rtl/conv_calc_seq.sv | 138 +++++++++++++
 tb/tb_conv_calc_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the conv layers: default widths, clog2 and the
// round/shift and signed-saturation steps applied to every conv output.
package conv_pkg;

  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned DEF_W_W    = 8;
  localparam int unsigned DEF_OUT_W  = 14;
  localparam int unsigned CALC_W     = 64;

  typedef struct packed {
    logic                     ovf;
    logic signed [CALC_W-1:0] val;
  } sat_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Index width that stays at least one bit for single-entry ranges
  function automatic int unsigned idx_w(input int unsigned v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

  function automatic logic signed [CALC_W-1:0] round_shift(
    input logic signed [CALC_W-1:0] v,
    input int unsigned              sh,
    input logic                     rnd
  );
    logic signed [CALC_W-1:0] r;
    r = v;
    if (rnd && sh > 0) r = v + (CALC_W'(1) << (sh - 1));
    return r >>> sh;
  endfunction

  function automatic sat_t sat_signed(
    input logic signed [CALC_W-1:0] v,
    input int unsigned              w
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    sat_t s;
    hi    = $signed((CALC_W'(1) << (w - 1)) - CALC_W'(1));
    lo    = ~hi;
    s.ovf = 1'b0;
    s.val = v;
    if (v > hi) begin
      s.ovf = 1'b1;
      s.val = hi;
    end else if (v < lo) begin
      s.ovf = 1'b1;
      s.val = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/conv_dot.sv
// K-tap signed dot product: one multiplier per tap feeding a full-precision sum.
module conv_dot
  import conv_pkg::*;
#(
  parameter int unsigned  K      = 25,
  parameter int unsigned  DATA_W = DEF_DATA_W,
  parameter int unsigned  W_W    = DEF_W_W,
  localparam int unsigned DOT_W  = DATA_W + W_W + clog2(K)
) (
  input  logic [K*DATA_W-1:0]      data,
  input  logic [K*W_W-1:0]         wts,
  output logic signed [DOT_W-1:0]  dot
);

  localparam int unsigned P_W = DATA_W + W_W;

  logic signed [P_W-1:0] prod [K];

  for (genvar j = 0; j < K; j++) begin : g_mul
    mul_24x24 #(
      .A_W (DATA_W),
      .B_W (W_W)
    ) u_mul (
      .a (data[j*DATA_W +: DATA_W]),
      .b (wts[j*W_W +: W_W]),
      .p (prod[j])
    );
  end

  always_comb begin
    dot = '0;
    for (int j = 0; j < K; j++) dot = dot + DOT_W'(prod[j]);
  end

endmodule

// File: rtl/mul_24x24.sv
// Signed multiplier wrapper; kept as its own module so an approximate
// multiplier can be dropped in without touching the dot-product tree.
module mul_24x24 #(
  parameter int unsigned A_W = 24,
  parameter int unsigned B_W = 24
) (
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] p
);

  assign p = (A_W+B_W)'(a) * (A_W+B_W)'(b);

endmodule

// File: rtl/conv_calc_seq.sv
// Channel-serial conv sum: one K-tap window per beat, N_CH beats per output,
// bias add, round/shift and saturation, with a runtime-writable weight file.
module conv_calc_seq
  import conv_pkg::*;
#(
  parameter int unsigned  N_CH   = 3,
  parameter int unsigned  K      = 25,
  parameter int unsigned  DATA_W = DEF_DATA_W,
  parameter int unsigned  W_W    = DEF_W_W,
  parameter int unsigned  BIAS_W = 16,
  parameter int unsigned  OUT_W  = DEF_OUT_W,
  parameter int unsigned  SHIFT  = 6,
  parameter int unsigned  ROUND  = 1,
  localparam int unsigned AW     = idx_w(N_CH * K),
  localparam int unsigned CW     = idx_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K*DATA_W-1:0]      in_data,
  input  logic                     flush,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic signed [W_W-1:0]    w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_ovf,
  output logic [CW-1:0]            ch_idx
);

  localparam int unsigned DOT_W = DATA_W + W_W + clog2(K);
  localparam int unsigned ACC_W = DATA_W + W_W + clog2(K) + clog2(N_CH) + 1;
  localparam int unsigned N_W   = N_CH * K;

  logic signed [W_W-1:0]   w_q [N_W];
  logic signed [W_W-1:0]   w_d [N_W];
  logic [CW-1:0]           ch_q, ch_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;

  logic [K*W_W-1:0]        w_sel;
  logic signed [DOT_W-1:0] dot;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_base;
  sat_t                    sat;
  logic                    accept;
  logic                    last;
  logic                    unused_sat_hi;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ch_idx    = ch_q;

  // Weight row for the channel expected on this beat
  always_comb begin
    w_sel = '0;
    for (int j = 0; j < K; j++) begin
      w_sel[j*W_W +: W_W] = w_q[AW'(32'(ch_q) * K + j)];
    end
  end

  conv_dot #(
    .K      (K),
    .DATA_W (DATA_W),
    .W_W    (W_W)
  ) u_dot (
    .data (in_data),
    .wts  (w_sel),
    .dot  (dot)
  );

  // The array update sees only the write port; beats read w_q (old value)
  always_comb begin
    w_d = w_q;
    if (w_we && 32'(w_addr) < N_W) w_d[w_addr] = w_data;
  end

  always_comb begin
    accept      = in_valid && in_ready;
    last        = (ch_q == CW'(N_CH - 1));
    sum         = acc_q + ACC_W'(dot) + ACC_W'(bias);
    acc_base    = (ch_q == '0) ? ACC_W'(0) : acc_q;
    sat         = sat_signed(round_shift(CALC_W'(sum), SHIFT, ROUND != 0), OUT_W);
    ch_d        = ch_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // Flush wins over a beat presented in the same cycle
    if (flush) begin
      ch_d  = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last) begin
        out_valid_d = 1'b1;
        out_data_d  = OUT_W'(sat.val);
        out_ovf_d   = sat.ovf;
        ch_d        = '0;
        acc_d       = '0;
      end else begin
        acc_d = acc_base + ACC_W'(dot);
        ch_d  = ch_q + CW'(1);
      end
    end
  end

  // Above OUT_W the saturated value is pure sign extension
  assign unused_sat_hi = ^sat.val[CALC_W-1:OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_W; i++) w_q[i] <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      w_q         <= w_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_conv_calc_seq.sv
// Scoreboard bench for conv_calc_seq: an input observer models each accepted
// frame arithmetically and queues the result; an output monitor retires it.
module tb_conv_calc_seq;

  localparam int N_CH    = 3;
  localparam int K       = 25;
  localparam int DATA_W  = 12;
  localparam int W_W     = 8;
  localparam int BIAS_W  = 16;
  localparam int OUT_W   = 14;
  localparam int SHIFT   = 6;
  localparam int ROUND   = 1;
  localparam int NW      = N_CH * K;
  localparam int OUT_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W - 1));

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [K*DATA_W-1:0] in_data;
  logic                flush;
  logic [BIAS_W-1:0]   bias;
  logic                w_we;
  logic [6:0]          w_addr;
  logic [W_W-1:0]      w_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_ovf;
  logic [1:0]          ch_idx;

  conv_calc_seq #(
    .N_CH (N_CH), .K (K), .DATA_W (DATA_W), .W_W (W_W), .BIAS_W (BIAS_W),
    .OUT_W (OUT_W), .SHIFT (SHIFT), .ROUND (ROUND)
  ) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .flush (flush), .bias (bias), .w_we (w_we),
    .w_addr (w_addr), .w_data (w_data), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data), .out_ovf (out_ovf),
    .ch_idx (ch_idx)
  );

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  int     checks = 0;
  int     fails  = 0;
  int     mw [NW];
  longint frame_dots [$];
  exp_t   exp_q [$];
  int     taps [K];
  bit     rand_rdy = 0;
  bit     hold_prev = 0;
  int     held_data;
  bit     held_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic void check(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic int sout(logic [OUT_W-1:0] v);
    logic signed [OUT_W-1:0] s;
    s = v;
    return int'(s);
  endfunction

  // Reference: sum of channel dots plus bias, rounded, floor-shifted, clamped
  function automatic void close_frame(longint b);
    longint s;
    longint q;
    exp_t   e;
    s = b;
    foreach (frame_dots[i]) s += frame_dots[i];
    if (ROUND != 0) s += longint'(2 ** (SHIFT - 1));
    q = s >>> SHIFT;
    e.ovf = 1'b0;
    if (q > OUT_MAX) begin
      q = OUT_MAX;
      e.ovf = 1'b1;
    end else if (q < OUT_MIN) begin
      q = OUT_MIN;
      e.ovf = 1'b1;
    end
    e.data = int'(q);
    exp_q.push_back(e);
    frame_dots.delete();
  endfunction

  // Input observer: model beats, flushes and weight writes in edge order
  initial begin
    logic signed [DATA_W-1:0] t_s;
    logic signed [BIAS_W-1:0] b_s;
    logic signed [W_W-1:0]    w_s;
    longint                   d;
    int                       ch;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ch_idx", longint'(ch_idx), longint'(frame_dots.size()));
        if (flush) begin
          frame_dots.delete();
        end else if (in_valid && in_ready) begin
          ch = frame_dots.size();
          d  = 0;
          for (int j = 0; j < K; j++) begin
            t_s = in_data[j*DATA_W +: DATA_W];
            d  += longint'(t_s) * longint'(mw[ch*K + j]);
          end
          frame_dots.push_back(d);
          if (frame_dots.size() == N_CH) begin
            b_s = bias;
            close_frame(longint'(b_s));
          end
        end
        if (w_we && int'(w_addr) < NW) begin
          w_s = w_data;
          mw[w_addr] = int'(w_s);
        end
      end
    end
  end

  // Output monitor: retire on handshake, enforce hold and backpressure
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", longint'(out_valid), 1);
          check("hold_data", sout(out_data), held_data);
          check("hold_ovf", longint'(out_ovf), longint'(held_ovf));
        end
        if (out_valid && !out_ready) check("in_ready_bp", longint'(in_ready), 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_out: got data %0d with no result outstanding, required none", sout(out_data));
          end else begin
            e = exp_q.pop_front();
            check("out_data", sout(out_data), e.data);
            check("out_ovf", longint'(out_ovf), longint'(e.ovf));
          end
        end
        hold_prev = out_valid && !out_ready;
        held_data = sout(out_data);
        held_ovf  = out_ovf;
      end
    end
  end

  task automatic wr_w(input int addr, input int val);
    w_we   = 1'b1;
    w_addr = 7'(addr);
    w_data = 8'(val);
    @(posedge clk); #1;
    w_we   = 1'b0;
  endtask

  task automatic set_all_w(input int val);
    for (int i = 0; i < NW; i++) wr_w(i, val);
  endtask

  task automatic fill_taps(input int val);
    for (int j = 0; j < K; j++) taps[j] = val;
  endtask

  task automatic send_beat(input int b);
    bit got;
    got = 1'b0;
    for (int j = 0; j < K; j++) in_data[j*DATA_W +: DATA_W] = 12'(taps[j]);
    bias     = 16'(b);
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (in_ready && !flush) got = 1'b1;
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout: got no acceptance in 400 cycles, required acceptance");
    end
  endtask

  task automatic send_frame(input int tap_val, input int b);
    fill_taps(tap_val);
    for (int c = 0; c < N_CH; c++) send_beat(b);
  endtask

  // Called right after the last beat's accepting edge (+1)
  task automatic expect_next(string nm, input int val, input bit ovf);
    @(negedge clk);
    check({nm, "_valid"}, longint'(out_valid), 1);
    check(nm, sout(out_data), val);
    check({nm, "_ovf"}, longint'(out_ovf), longint'(ovf));
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    frame_dots.delete();
    for (int i = 0; i < NW; i++) mw[i] = 0;
    hold_prev = 1'b0;
  endtask

  initial begin
    int b;
    bit big;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    bias      = '0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", sout(out_data), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_ch_idx", longint'(ch_idx), 0);
    @(posedge clk); #1;

    // All-ones weights, taps 64: 4800 -> 75, one cycle after the last beat
    set_all_w(1);
    send_frame(64, 0);
    expect_next("ones", 75, 1'b0);

    // Single nonzero weight: rounding up and rounding of negatives
    set_all_w(0);
    wr_w(0, 1);
    fill_taps(0); taps[0] = 96;
    send_beat(0);
    fill_taps(0);
    send_beat(0); send_beat(0);
    expect_next("round_pos", 2, 1'b0);
    taps[0] = -96;
    send_beat(0);
    fill_taps(0);
    send_beat(0); send_beat(0);
    expect_next("round_neg", -1, 1'b0);

    // Saturation in both directions
    set_all_w(127);
    send_frame(2047, 0);
    expect_next("sat_pos", OUT_MAX, 1'b1);
    set_all_w(-128);
    send_frame(2047, 0);
    expect_next("sat_neg", OUT_MIN, 1'b1);

    // Backpressure: result held 5 cycles while the next frame waits
    set_all_w(1);
    out_ready = 1'b0;
    send_frame(64, 0);
    fork
      send_frame(128, 0);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    expect_next("bp_next", 150, 1'b0);

    // Flush after two beats discards them and the beat in the flush cycle
    fill_taps(200);
    send_beat(0); send_beat(0);
    do_flush();
    send_frame(64, 0);
    expect_next("flush", 75, 1'b0);

    // Weight write alongside a channel-0 beat: old weight now, new one next
    fill_taps(64);
    fork
      send_beat(0);
      wr_w(0, 5);
    join
    send_beat(0); send_beat(0);
    expect_next("wr_old", 75, 1'b0);
    wr_w(100, 50);
    send_frame(64, 0);
    expect_next("wr_new", 79, 1'b0);

    // Asynchronous reset mid-frame
    send_beat(0); send_beat(0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_ch_idx", longint'(ch_idx), 0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    fill_taps(300);
    send_beat(0); send_beat(0); send_beat(640);
    expect_next("post_rst", 10, 1'b0);

    // Randomised frames with random backpressure, flushes and weight writes
    rand_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      if (f % 25 == 0) begin
        for (int i = 0; i < NW; i++) begin
          if (f % 50 == 0) wr_w(i, int'($urandom_range(0, 255)) - 128);
          else             wr_w(i, int'($urandom_range(0, 15)) - 8);
        end
      end
      big = 1'($urandom_range(0, 1));
      for (int c = 0; c < N_CH; c++) begin
        for (int j = 0; j < K; j++) begin
          taps[j] = big ? int'($urandom_range(0, 4095)) - 2048
                        : int'($urandom_range(0, 127)) - 64;
        end
        b = int'($urandom_range(0, 65535)) - 32768;
        if ($urandom_range(0, 7) == 0) begin
          fork
            send_beat(b);
            wr_w(int'($urandom_range(0, 99)), int'($urandom_range(0, 255)) - 128);
          join
        end else begin
          send_beat(b);
        end
        if (c < N_CH - 1 && $urandom_range(0, 19) == 0) do_flush();
      end
    end

    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_outstanding", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
